// File: rtl/cdc_pulse_scheduler_if.sv
// Requester-side bus of the pulse-crossing scheduler: event inputs, control,
// and the shared crossing line with its status flags.
interface cdc_pulse_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0] req;
   logic               enable;
   logic               ovf_clr;
   logic               xfer_pulse;
   logic [IDX_W-1:0]   xfer_id;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] overflow;
   logic               busy;

   modport master (
      output req, enable, ovf_clr,
      input  xfer_pulse, xfer_id, done, pending, overflow, busy
   );

   modport slave (
      input  req, enable, ovf_clr,
      output xfer_pulse, xfer_id, done, pending, overflow, busy
   );
endinterface

// File: rtl/cdc_pulse_scheduler.sv
// Round-robin scheduler sharing one slow-to-fast pulse-crossing channel:
// queues one event per requester, stretches each pulse, then enforces a gap.
module cdc_pulse_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   cdc_pulse_scheduler_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   xfer_id_q, xfer_id_d;
   logic               xfer_pulse_q, xfer_pulse_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] overflow_q, overflow_d;

   logic               found;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   cand;
   logic               grant;
   logic [NUM_REQ-1:0] grant_clr;
   logic [NUM_REQ-1:0] ovf_set;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && pending_q[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      xfer_id_d    = xfer_id_q;
      xfer_pulse_d = xfer_pulse_q;
      done_d       = '0;
      grant        = 1'b0;
      grant_clr    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.enable && found) begin
               grant             = 1'b1;
               grant_clr[winner] = 1'b1;
               state_d           = ST_HOLD;
               xfer_pulse_d      = 1'b1;
               xfer_id_d         = winner;
               rr_ptr_d          = winner;
               cnt_d             = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d           = ST_GAP;
               xfer_pulse_d      = 1'b0;
               done_d[xfer_id_q] = 1'b1;
               cnt_d             = CNT_W'(GAP_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);

      // A request landing on its own grant edge re-queues rather than overflowing.
      ovf_set    = bus.req & pending_q & ~grant_clr;
      pending_d  = (pending_q & ~grant_clr) | bus.req;
      overflow_d = bus.ovf_clr ? ovf_set : (overflow_q | ovf_set);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
         xfer_id_q    <= '0;
         xfer_pulse_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= '0;
         pending_q    <= '0;
         overflow_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         xfer_id_q    <= xfer_id_d;
         xfer_pulse_q <= xfer_pulse_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
      end
   end

   assign bus.xfer_pulse = xfer_pulse_q;
   assign bus.xfer_id    = xfer_id_q;
   assign bus.done       = done_q;
   assign bus.pending    = pending_q;
   assign bus.overflow   = overflow_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants and per-cycle
// flags; a posedge monitor pops and compares against the scheduler outputs.
module tb_cdc_pulse_scheduler;
   localparam int N = 4;
   localparam int H = 2;
   localparam int G = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cdc_pulse_scheduler_if #(.NUM_REQ(N), .IDX_W(2)) bus ();

   cdc_pulse_scheduler #(
      .NUM_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic [N-1:0] pend;
      logic [N-1:0] ovf;
      logic [N-1:0] done;
      logic         busy;
      logic         pulse;
      logic [1:0]   id;
   } snap_t;

   typedef struct {
      int id;
      int cyc;
   } grant_t;

   snap_t  snap_q[$];
   grant_t grant_q[$];
   int     total = 0;
   int     bad   = 0;

   // Model: channel is free again H+G+1 edges after a grant.
   logic [N-1:0] m_pend, m_ovf;
   int           m_last, m_cyc, g_cyc, g_id;
   bit           m_have;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_ovf  = '0;
      m_last = N - 1;
      m_cyc  = 0;
      m_have = 0;
      g_cyc  = 0;
      g_id   = 0;
      snap_q.delete();
      grant_q.delete();
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic en, input logic clr);
      snap_t        s;
      logic [N-1:0] dup;
      bit           hit;
      grant_t       gr;
      if (en && m_pend != '0 && (!m_have || m_cyc >= g_cyc + H + G + 1)) begin
         hit = 0;
         for (int k = 1; k <= N; k++) begin
            if (!hit && m_pend[(m_last + k) % N]) begin
               hit  = 1;
               g_id = (m_last + k) % N;
            end
         end
         m_pend[g_id] = 1'b0;
         m_last       = g_id;
         g_cyc        = m_cyc;
         m_have       = 1;
         gr.id        = g_id;
         gr.cyc       = m_cyc;
         grant_q.push_back(gr);
      end
      dup    = r & m_pend;
      m_pend = m_pend | r;
      m_ovf  = clr ? dup : (m_ovf | dup);
      s.pend  = m_pend;
      s.ovf   = m_ovf;
      s.pulse = m_have && (m_cyc < g_cyc + H);
      s.busy  = m_have && (m_cyc < g_cyc + H + G);
      s.done  = (m_have && m_cyc == g_cyc + H) ? (N'(1) << g_id) : '0;
      s.id    = 2'(g_id);
      snap_q.push_back(s);
      m_cyc++;
   endtask

   // Inputs change at a negedge and are modelled for the following posedge.
   task automatic cycle(input logic [N-1:0] r, input logic en, input logic clr);
      bus.req     = r;
      bus.enable  = en;
      bus.ovf_clr = clr;
      model_step(r, en, clr);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, 1'b1, 1'b0);
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      bus.req     = '0;
      bus.enable  = 1'b0;
      bus.ovf_clr = 1'b0;
      model_reset();
      #1;
      check("rst_pulse",    32'(bus.xfer_pulse), 32'd0);
      check("rst_busy",     32'(bus.busy),       32'd0);
      check("rst_pending",  32'(bus.pending),    32'd0);
      check("rst_overflow", 32'(bus.overflow),   32'd0);
      check("rst_done",     32'(bus.done),       32'd0);
      check("rst_id",       32'(bus.xfer_id),    32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor
   int   ecyc       = 0;
   logic prev_pulse = 1'b0;

   always @(posedge clk) begin
      snap_t  s;
      grant_t gr;
      #1;
      if (!reset_n) begin
         ecyc       = 0;
         prev_pulse = 1'b0;
      end else begin
         if (snap_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL snap_underflow: got empty expected entry at cycle %0d", ecyc);
         end else begin
            s = snap_q.pop_front();
            check("pending",  32'(bus.pending),    32'(s.pend));
            check("overflow", 32'(bus.overflow),   32'(s.ovf));
            check("done",     32'(bus.done),       32'(s.done));
            check("busy",     32'(bus.busy),       32'(s.busy));
            check("pulse",    32'(bus.xfer_pulse), 32'(s.pulse));
            check("xfer_id",  32'(bus.xfer_id),    32'(s.id));
         end
         if (bus.xfer_pulse && !prev_pulse) begin
            if (grant_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL grant_unexpected: got id %0d expected no grant at cycle %0d",
                        bus.xfer_id, ecyc);
            end else begin
               gr = grant_q.pop_front();
               check("grant_id",  32'(bus.xfer_id), 32'(gr.id));
               check("grant_cyc", 32'(ecyc),        32'(gr.cyc));
            end
         end
         prev_pulse = bus.xfer_pulse;
         ecyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] r;
      bus.req     = '0;
      bus.enable  = 1'b0;
      bus.ovf_clr = 1'b0;
      @(negedge clk);
      apply_reset();

      // single request
      cycle(4'b0001, 1'b1, 1'b0);
      idle(8);
      // simultaneous requests: grants 0,1,3
      cycle(4'b1011, 1'b1, 1'b0);
      idle(18);
      // fairness with sustained requests, then overflow clear
      for (int i = 0; i < 40; i++) cycle(4'b0101, 1'b1, 1'b0);
      idle(15);
      cycle('0, 1'b1, 1'b1);
      idle(2);
      // collision on requester 1's grant edge
      cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0);
      idle(12);
      // enable dropped mid-HOLD with requester 2 pending
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle('0, 1'b0, 1'b0);
      check("en_off_pending", 32'(bus.pending), 32'h4);
      idle(8);
      // reset during HOLD
      cycle(4'b0100, 1'b1, 1'b0);
      cycle(4'b0011, 1'b1, 1'b0);
      check("pre_rst_pulse", 32'(bus.xfer_pulse), 32'd1);
      apply_reset();
      cycle(4'b1111, 1'b1, 1'b0);
      idle(25);

      // randomized traffic with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         for (int b = 0; b < N; b++) r[b] = ($urandom_range(7) == 0);
         cycle(r, ($urandom_range(9) != 0), ($urandom_range(19) == 0));
      end
      idle(12);
      check("grants_drained", 32'(grant_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
